// File: rtl/soe_stim_checker_if.sv
// Bundle between the campaign controller / DUT-golden pair and the stimulus-compare engine.
// start is a one-cycle request, accepted only while busy=0; a start seen with busy=1 is dropped and
// produces no response. seed, max_cycles and out_mask are read only in the cycle start is accepted.
interface soe_stim_checker_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 2,
  parameter int CNT_W = 16,
  parameter int CYC_W = 32
);
  logic                   start;
  logic [31:0]            seed;
  logic [CYC_W-1:0]       max_cycles;
  logic [OUT_W-1:0]       out_mask;
  logic [IN_W-1:0]        stim;
  logic [OUT_W-1:0]       dut_out;
  logic [OUT_W-1:0]       gold_out;
  logic                   busy;
  logic                   done;
  logic [OUT_W*CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0]       soe_total;
  logic [CYC_W-1:0]       first_err_cyc;
  logic                   first_err_vld;

  modport master (
    output start, seed, max_cycles, out_mask, dut_out, gold_out,
    input  stim, busy, done, err_cnt, soe_total, first_err_cyc, first_err_vld
  );

  modport slave (
    input  start, seed, max_cycles, out_mask, dut_out, gold_out,
    output stim, busy, done, err_cnt, soe_total, first_err_cyc, first_err_vld
  );
endinterface

// File: rtl/soe_stim_checker.sv
// LFSR stimulus generator with delayed DUT-vs-golden compare and saturating
// per-channel / total sum-of-errors counters for fault-injection runs.
module soe_stim_checker #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 2,
  parameter int DELAY = 2,
  parameter int CNT_W = 16,
  parameter int CYC_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  soe_stim_checker_if.slave  bus,
  output logic [1:0]         state_dbg
);
  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_RUN   = 2'd1;
  localparam logic [1:0]  S_DRAIN = 2'd2;
  localparam logic [1:0]  S_DONE  = 2'd3;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam int PD = (DELAY > 1) ? DELAY - 1 : 1;
  localparam int DW = $clog2(DELAY + 1);

  logic [1:0]       state_q;
  logic [31:0]      lfsr_q;
  logic [31:0]      lfsr_next;
  logic [CYC_W-1:0] k_q;
  logic [CYC_W-1:0] max_q;
  logic [OUT_W-1:0] mask_q;
  logic [IN_W-1:0]  stim_q;
  logic [DW-1:0]    drain_q;
  logic [PD-1:0]    vld_q;
  logic [CYC_W-1:0] idx_q [PD];
  logic [CNT_W-1:0] err_q [OUT_W];
  logic [CNT_W-1:0] soe_q;
  logic [CYC_W-1:0] first_cyc_q;
  logic             first_vld_q;

  logic             start_ok;
  logic             issue;
  logic             cmp_vld;
  logic [CYC_W-1:0] cmp_idx;
  logic [OUT_W-1:0] mis;

  assign start_ok  = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign issue     = (state_q == S_RUN);
  assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
  assign mis       = (bus.dut_out ^ bus.gold_out) & mask_q;

  // The issue strobe itself is pipe stage 0, so only DELAY-1 registers sit
  // between a vector appearing on stim and its compare edge.
  generate
    if (DELAY == 1) begin : g_tap_direct
      assign cmp_vld = issue;
      assign cmp_idx = k_q;
    end else begin : g_tap_piped
      assign cmp_vld = vld_q[PD-1];
      assign cmp_idx = idx_q[PD-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= 32'h1;
      k_q         <= '0;
      max_q       <= '0;
      mask_q      <= '0;
      stim_q      <= '0;
      drain_q     <= '0;
      vld_q       <= '0;
      soe_q       <= '0;
      first_cyc_q <= '0;
      first_vld_q <= 1'b0;
      for (int j = 0; j < PD; j++) idx_q[j] <= '0;
      for (int i = 0; i < OUT_W; i++) err_q[i] <= '0;
    end else begin
      vld_q[0] <= issue;
      idx_q[0] <= k_q;
      for (int j = 1; j < PD; j++) begin
        vld_q[j] <= vld_q[j-1];
        idx_q[j] <= idx_q[j-1];
      end

      if (cmp_vld) begin
        for (int i = 0; i < OUT_W; i++) begin
          if (mis[i] && (err_q[i] != '1)) err_q[i] <= err_q[i] + 1'b1;
        end
        if (|mis) begin
          if (soe_q != '1) soe_q <= soe_q + 1'b1;
          if (!first_vld_q) begin
            first_cyc_q <= cmp_idx;
            first_vld_q <= 1'b1;
          end
        end
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            lfsr_q      <= (bus.seed == 32'h0) ? 32'h1 : bus.seed;
            mask_q      <= bus.out_mask;
            max_q       <= bus.max_cycles;
            k_q         <= '0;
            drain_q     <= '0;
            vld_q       <= '0;
            soe_q       <= '0;
            first_cyc_q <= '0;
            first_vld_q <= 1'b0;
            for (int i = 0; i < OUT_W; i++) err_q[i] <= '0;
            state_q     <= (bus.max_cycles == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          lfsr_q <= lfsr_next;
          stim_q <= lfsr_q[IN_W-1:0];
          k_q    <= k_q + 1'b1;
          if (k_q == max_q - 1'b1) begin
            drain_q <= '0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          drain_q <= drain_q + 1'b1;
          if (drain_q == DW'(DELAY - 1)) state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.err_cnt = '0;
    for (int i = 0; i < OUT_W; i++) bus.err_cnt[i*CNT_W +: CNT_W] = err_q[i];
  end

  assign bus.stim          = issue ? lfsr_q[IN_W-1:0] : stim_q;
  assign bus.busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done          = (state_q == S_DONE);
  assign bus.soe_total     = soe_q;
  assign bus.first_err_cyc = first_cyc_q;
  assign bus.first_err_vld = first_vld_q;
  assign state_dbg         = state_q;
endmodule

// File: tb/tb_soe_stim_checker.sv
// Bench for soe_stim_checker: a fault pattern per vector index drives the expected
// counts; a second instance with 4-bit counters shares all inputs for saturation.
module tb_soe_stim_checker;
  localparam int IN_W  = 3;
  localparam int OUT_W = 2;
  localparam int DELAY = 2;
  localparam int CNT_W = 16;
  localparam int CYC_W = 32;
  localparam int SAT_W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;
  logic [1:0] sat_state_dbg;
  int         errors = 0;
  int         checks = 0;

  logic [IN_W-1:0] exp_q[$];
  logic [IN_W-1:0] stim_log[$];
  logic [IN_W-1:0] log_a[$];

  soe_stim_checker_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .CYC_W(CYC_W)) bus ();
  soe_stim_checker_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(SAT_W), .CYC_W(CYC_W)) sat_bus ();

  assign sat_bus.start      = bus.start;
  assign sat_bus.seed       = bus.seed;
  assign sat_bus.max_cycles = bus.max_cycles;
  assign sat_bus.out_mask   = bus.out_mask;
  assign sat_bus.dut_out    = bus.dut_out;
  assign sat_bus.gold_out   = bus.gold_out;

  soe_stim_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .DELAY(DELAY), .CNT_W(CNT_W), .CYC_W(CYC_W)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  soe_stim_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .DELAY(DELAY), .CNT_W(SAT_W), .CYC_W(CYC_W)) u_sat (
    .clk(clk), .rst(rst), .bus(sat_bus), .state_dbg(sat_state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // One complete run from IDLE/DONE. Fault modes: 0 none, 1 channel 1 inverted,
  // 2 both channels on vector inj_k only, 3 all channels always, 4 random.
  task automatic run_and_check(input string name, input logic [31:0] seed_v, input int n,
                               input logic [OUT_W-1:0] mask_v, input int mode, input int inj_k,
                               input bit start_in_drain);
    logic [OUT_W-1:0] fault_k[$];
    logic [OUT_W-1:0] f;
    logic [31:0]      l;
    logic [IN_W-1:0]  exp_stim;
    logic [IN_W-1:0]  last_vec;
    int               exp_err[OUT_W];
    int               exp_soe, exp_first, seen, k, kv;
    bit               exp_fv;
    bit               exp_busy, exp_done;

    l = (seed_v == 32'h0) ? 32'h1 : seed_v;
    exp_q.delete();
    stim_log.delete();
    exp_soe = 0; exp_first = 0; exp_fv = 1'b0;
    for (int i = 0; i < OUT_W; i++) exp_err[i] = 0;
    for (int j = 0; j < n; j++) begin
      exp_q.push_back(l[IN_W-1:0]);
      l = lfsr_step(l);
      case (mode)
        0:       f = '0;
        1:       f = 2'b10;
        2:       f = (j == inj_k) ? {OUT_W{1'b1}} : '0;
        3:       f = {OUT_W{1'b1}};
        default: f = OUT_W'($urandom_range(0, (1 << OUT_W) - 1));
      endcase
      fault_k.push_back(f);
      f = f & mask_v;
      for (int i = 0; i < OUT_W; i++) if (f[i] && exp_err[i] < (1 << CNT_W) - 1) exp_err[i]++;
      if (f != '0) begin
        if (exp_soe < (1 << CNT_W) - 1) exp_soe++;
        if (!exp_fv) begin exp_first = j; exp_fv = 1'b1; end
      end
    end

    @(posedge clk); #1;
    bus.start = 1'b1; bus.seed = seed_v; bus.max_cycles = CYC_W'(n); bus.out_mask = mask_v;
    @(posedge clk); #1;
    bus.start = 1'b0;
    seen = 0;
    last_vec = '0;
    for (int c = 1; c <= n + DELAY + 1; c++) begin
      k = c - DELAY;
      bus.gold_out = OUT_W'($urandom);
      if (k >= 0 && k < n) f = fault_k[k];
      else f = OUT_W'($urandom);
      bus.dut_out = bus.gold_out ^ f;
      bus.start = start_in_drain && (c == n + 1);
      @(negedge clk);
      kv = c - DELAY - 1;
      if (kv >= 0 && kv < n && ((fault_k[kv] & mask_v) != '0)) seen++;
      exp_busy = (n > 0) && (c <= n + DELAY);
      exp_done = (n == 0) || (c > n + DELAY);
      checks++;
      if (bus.busy !== exp_busy) begin
        errors++; $display("FAIL %s busy c=%0d: got %b expected %b", name, c, bus.busy, exp_busy);
      end
      checks++;
      if (bus.done !== exp_done) begin
        errors++; $display("FAIL %s done c=%0d: got %b expected %b", name, c, bus.done, exp_done);
      end
      checks++;
      if (bus.soe_total !== CNT_W'(seen)) begin
        errors++; $display("FAIL %s running_soe c=%0d: got %0d expected %0d", name, c, bus.soe_total, seen);
      end
      if (n > 0) begin
        if (c <= n) begin
          exp_stim = exp_q.pop_front();
          last_vec = exp_stim;
          stim_log.push_back(bus.stim);
        end else begin
          exp_stim = last_vec;
        end
        checks++;
        if (bus.stim !== exp_stim) begin
          errors++; $display("FAIL %s stim c=%0d: got %0h expected %0h", name, c, bus.stim, exp_stim);
        end
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;

    for (int i = 0; i < OUT_W; i++) begin
      checks++;
      if (bus.err_cnt[i*CNT_W +: CNT_W] !== CNT_W'(exp_err[i])) begin
        errors++;
        $display("FAIL %s err_cnt[%0d]: got %0d expected %0d", name, i, bus.err_cnt[i*CNT_W +: CNT_W], exp_err[i]);
      end
    end
    checks++;
    if (bus.soe_total !== CNT_W'(exp_soe)) begin
      errors++; $display("FAIL %s soe_total: got %0d expected %0d", name, bus.soe_total, exp_soe);
    end
    checks++;
    if (bus.first_err_vld !== exp_fv) begin
      errors++; $display("FAIL %s first_err_vld: got %b expected %b", name, bus.first_err_vld, exp_fv);
    end
    if (exp_fv) begin
      checks++;
      if (bus.first_err_cyc !== CYC_W'(exp_first)) begin
        errors++; $display("FAIL %s first_err_cyc: got %0d expected %0d", name, bus.first_err_cyc, exp_first);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.stim, bus.busy, bus.done, bus.err_cnt, bus.soe_total, bus.first_err_cyc, bus.first_err_vld} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: stim=%0h busy=%b done=%b err=%0h soe=%0d fcyc=%0d fvld=%b expected all 0",
               bus.stim, bus.busy, bus.done, bus.err_cnt, bus.soe_total, bus.first_err_cyc, bus.first_err_vld);
    end
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0 (IDLE)", state_dbg);
    end
  endtask

  task automatic test_golden_equal();
    run_and_check("golden_equal", 32'd1234, 20, 2'b11, 0, 0, 1'b0);
  endtask

  task automatic test_stuck_channel();
    run_and_check("stuck_ch1", 32'hCAFE_0001, 20, 2'b11, 1, 0, 1'b0);
  endtask

  task automatic test_single_injection();
    run_and_check("inject_k7_mask11", 32'h0000_BEEF, 20, 2'b11, 2, 7, 1'b0);
    run_and_check("inject_k7_mask01", 32'h0000_BEEF, 20, 2'b01, 2, 7, 1'b0);
  endtask

  task automatic test_saturation();
    run_and_check("permanent_40", 32'h1357_9BDF, 40, 2'b11, 3, 0, 1'b0);
    for (int i = 0; i < OUT_W; i++) begin
      checks++;
      if (sat_bus.err_cnt[i*SAT_W +: SAT_W] !== 4'd15) begin
        errors++; $display("FAIL sat_err_cnt[%0d]: got %0d expected 15", i, sat_bus.err_cnt[i*SAT_W +: SAT_W]);
      end
    end
    checks++;
    if (sat_bus.soe_total !== 4'd15) begin
      errors++; $display("FAIL sat_soe_total: got %0d expected 15", sat_bus.soe_total);
    end
    checks++;
    if (sat_bus.done !== 1'b1 || sat_bus.first_err_vld !== 1'b1 || sat_bus.first_err_cyc !== '0) begin
      errors++;
      $display("FAIL sat_status: done=%b fvld=%b fcyc=%0d expected 1 1 0",
               sat_bus.done, sat_bus.first_err_vld, sat_bus.first_err_cyc);
    end
  endtask

  task automatic test_seed_repeat();
    logic [31:0] s;
    run_and_check("seed0", 32'h0, 16, 2'b11, 4, 0, 1'b0);
    log_a = stim_log;
    run_and_check("seed1", 32'h1, 16, 2'b11, 4, 0, 1'b0);
    checks++;
    if (stim_log.size() != log_a.size()) begin
      errors++; $display("FAIL seed0_vs_seed1 length: got %0d expected %0d", stim_log.size(), log_a.size());
    end else begin
      for (int i = 0; i < log_a.size(); i++) begin
        checks++;
        if (stim_log[i] !== log_a[i]) begin
          errors++; $display("FAIL seed0_vs_seed1 vec %0d: got %0h expected %0h", i, stim_log[i], log_a[i]);
        end
      end
    end
    s = $urandom;
    run_and_check("same_seed_a", s, 16, 2'b10, 4, 0, 1'b0);
    log_a = stim_log;
    run_and_check("same_seed_b", s, 16, 2'b01, 4, 0, 1'b0);
    for (int i = 0; i < log_a.size(); i++) begin
      checks++;
      if (stim_log[i] !== log_a[i]) begin
        errors++; $display("FAIL same_seed vec %0d: got %0h expected %0h", i, stim_log[i], log_a[i]);
      end
    end
  endtask

  task automatic test_zero_length();
    run_and_check("zero_length", 32'h55, 0, 2'b11, 3, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      run_and_check($sformatf("random_%0d", r), $urandom, $urandom_range(1, 30),
                    OUT_W'($urandom_range(0, 3)), 4, 0, 1'b0);
    end
  endtask

  task automatic test_reset_mid_run();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.seed = 32'h2468; bus.max_cycles = CYC_W'(20); bus.out_mask = 2'b11;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c < 6; c++) begin
      bus.gold_out = OUT_W'($urandom);
      bus.dut_out  = ~bus.gold_out;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.stim, bus.busy, bus.done, bus.err_cnt, bus.soe_total, bus.first_err_cyc, bus.first_err_vld} !== '0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: stim=%0h busy=%b done=%b err=%0h soe=%0d fcyc=%0d fvld=%b expected all 0",
               bus.stim, bus.busy, bus.done, bus.err_cnt, bus.soe_total, bus.first_err_cyc, bus.first_err_vld);
    end
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++; $display("FAIL midrun_reset_state: got %0d expected 0 (IDLE)", state_dbg);
    end
    run_and_check("start_in_drain", 32'h0BAD_F00D, 20, 2'b11, 4, 0, 1'b1);
  endtask

  initial begin
    bus.start = 1'b0; bus.seed = '0; bus.max_cycles = '0; bus.out_mask = '0;
    bus.dut_out = '0; bus.gold_out = '0;
    test_reset();
    test_golden_equal();
    test_stuck_channel();
    test_single_injection();
    test_saturation();
    test_seed_repeat();
    test_zero_length();
    test_random();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/soe_stim_checker.md
# soe_stim_checker

Synthesizable, parametrised stimulus-and-compare engine for fault-injection campaigns. It drives an LFSR-based pseudo-random input vector into a fault-injected design and its golden copy. It compares selected outputs after a programmable alignment delay and accumulates per-output and total sum-of-errors (SoE) counts over a bounded number of cycles. It sits between the campaign controller and the DUT/golden pair, and replaces file-based golden vectors with a live golden instance.

## Interface
- IN_W, 3, width of stimulus vector (1..32)
- OUT_W, 2, number of compared output bits (channels)
- DELAY, 2, cycles from stimulus issue to compare sample (>=1)
- CNT_W, 16, width of each error counter
- CYC_W, 32, width of cycle counter / max_cycles
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE
- seed  in  32  LFSR seed, sampled on accepted start
- max_cycles  in  CYC_W  number of stimulus vectors in the run
- out_mask  in  OUT_W  1 = channel compared; sampled on accepted start
- stim  out  IN_W  stimulus to both DUT and golden copy
- dut_out  in  OUT_W  fault-injected design outputs
- gold_out  in  OUT_W  golden design outputs
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE until next start or rst
- err_cnt  out  OUT_W*CNT_W  per-channel mismatch counts, channel i at [i*CNT_W +: CNT_W]
- soe_total  out  CNT_W  number of compare cycles with >=1 masked mismatch
- first_err_cyc  out  CYC_W  index of the stimulus vector that produced the first mismatch
- first_err_vld  out  1  first_err_cyc valid

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset state IDLE.
- IDLE/DONE + start: clear all counters, first_err_vld, and the valid pipe; load lfsr = (seed==0) ? 1 : seed; latch mask. Go to RUN, or to DONE directly if max_cycles==0 (counters stay 0).
- start in RUN/DRAIN: ignored.
- LFSR: 32-bit Galois, right shift, taps mask 32'h80200003; advances once per RUN cycle. stim = lfsr[IN_W-1:0] while RUN, holds last value in DRAIN/DONE.
- RUN: vector index k = 0..max_cycles-1, one per cycle. After issuing k = max_cycles-1, go to DRAIN.
- Valid pipe: DELAY-deep shift register of issue strobes tagged with k. When the strobe for index k exits, sample mis = (dut_out ^ gold_out) & mask.
- For each i with mis[i]=1, increment err_cnt[i]. If mis!=0, increment soe_total. If mis!=0 and !first_err_vld, set first_err_cyc=k and first_err_vld=1.
- All counters saturate at all-ones; no wrap.
- DRAIN: lasts exactly DELAY cycles, until the last strobe has been compared; then DONE.
- DONE: outputs hold until start or rst.
- rst at any time, including mid-RUN or mid-DRAIN: next edge returns to IDLE with all outputs at reset values; in-flight compares are discarded.

## Timing
- Reset values: stim=0, busy=0, done=0, err_cnt=0, soe_total=0, first_err_cyc=0, first_err_vld=0.
- Edge of accepted start (t0): busy=1 from t0+1; stim = seed-derived vector 0 during cycle t0+1.
- Vector k is driven during cycle t0+1+k. dut_out/gold_out are sampled at the edge ending cycle t0+1+k+DELAY-1, i.e. DELAY cycles after stim for k appears. Counters reflect k on the following cycle.
- Run of N vectors: busy high N+DELAY cycles; done rises at t0+1+N+DELAY; final counts are valid when done=1.
- max_cycles==0: done=1 at t0+1, busy never asserts.

## Test plan
- Golden equals DUT (gold_out tied to dut_out), IN_W=3, max_cycles=20, seed=1234 -> done after 20+DELAY busy cycles; all err_cnt=0, soe_total=0, first_err_vld=0.
- Channel 1 stuck-inverted versus golden, mask=2'b11, max_cycles=20 -> err_cnt[1]=20, err_cnt[0]=0, soe_total=20, first_err_cyc=0.
- Single mismatch injected only on the compare of vector 7, on both channels -> err_cnt={1,1}, soe_total=1, first_err_cyc=7; the same injection with mask=2'b01 -> err_cnt[1]=0.
- CNT_W=4, permanent mismatch, max_cycles=40 -> err_cnt and soe_total saturate at 15.
- seed=0 -> stim sequence identical to seed=1; two runs with the same seed -> identical stim sequence, checked cycle-by-cycle.
- rst asserted at vector 5 of a 20-vector run, then start pulsed during DRAIN of a following run -> after rst all outputs are 0 and state is IDLE; start during DRAIN is ignored and the run completes normally.
